// File: rtl/aes_enc_scheduler.sv
// ---------------------------------------------------------------------------
// aes_enc_scheduler
//
// Shares one fixed-latency, non-stallable, pipelined AES-256 encrypt datapath
// between NREQ plaintext sources. A round-robin arbiter issues at most one
// 128-bit block per clock. A shadow tag pipe runs beside the datapath and
// remembers which requester owns each block. Every ciphertext is steered into
// that requester's show-ahead result FIFO.
//
// The datapath cannot be back-pressured. A block is therefore only granted
// when its requester holds a credit, which is a result-FIFO slot reserved for
// it in advance. Each requester starts with RES_DEPTH credits. A grant spends
// one credit and a pop returns one.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both are
// high. req_ready is a combinational one-hot (or zero) grant that depends on
// req_valid. A requester may change req_valid/req_data in any cycle without
// a grant. res_valid never depends on res_ready.
//
// Ports
//   clk_clk        single clock
//   reset_reset    synchronous, active-high reset
//   key_ready      round keys valid; nothing is granted while low
//   req_valid      per-requester plaintext available
//   req_data       plaintext; requester i at [128*i +: 128]
//   req_ready      one-hot combinational grant
//   aes_in_valid   registered block strobe to the datapath
//   aes_in_data    registered plaintext to the datapath
//   aes_out_valid  ciphertext strobe from the datapath (LATENCY after input)
//   aes_out_data   ciphertext from the datapath
//   res_valid      result FIFO i non-empty
//   res_data       head of result FIFO i; zero while that FIFO is empty
//   res_ready      pop result FIFO i
//   inflight       number of blocks inside the datapath
//   err_tag        sticky: datapath strobe disagreed with the shadow tag
// ---------------------------------------------------------------------------
module aes_enc_scheduler #(
  parameter int NREQ      = 2,
  parameter int LATENCY   = 14,
  parameter int RES_DEPTH = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                key_ready,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [128*NREQ-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                aes_in_valid,
  output logic [127:0]        aes_in_data,
  input  logic                aes_out_valid,
  input  logic [127:0]        aes_out_data,
  output logic [NREQ-1:0]     res_valid,
  output logic [128*NREQ-1:0] res_data,
  input  logic [NREQ-1:0]     res_ready,
  output logic [4:0]          inflight,
  output logic                err_tag
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW  = $clog2(RES_DEPTH + 1);
  localparam int MW  = $clog2(LATENCY + 2);

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] has_credit;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [IDW-1:0]  scan_idx;
  logic [127:0]    sel_data;

  // A requester is never granted while reset is asserted. This keeps
  // req_ready at zero during reset, whatever the inputs are.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = key_ready & req_valid[i] & has_credit[i] & ~reset_reset;
    end
  end

  // The scan starts at rr_ptr and wraps. The first eligible index wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && elig[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_id        = scan_idx;
        grant_any       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = req_data[128*i +: 128];
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Issue register and shadow tag pipe
  // -------------------------------------------------------------------------
  // Tag stage 0 loads on the same edge as the datapath input register, so it
  // describes the block now on aes_in_*. The LATENCY further stages delay it
  // by the datapath latency. Stage LATENCY therefore lines up with the
  // ciphertext of that block on aes_out_*.
  logic [LATENCY:0]          tag_v;
  logic [LATENCY:0][IDW-1:0] tag_id;
  logic                      tag_out_v;
  logic [IDW-1:0]            tag_out_id;
  logic                      retire;

  assign tag_out_v  = tag_v[LATENCY];
  assign tag_out_id = tag_id[LATENCY];
  assign retire     = aes_out_valid & tag_out_v;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      aes_in_valid <= 1'b0;
      aes_in_data  <= '0;
      tag_v        <= '0;
      tag_id       <= '0;
    end else begin
      aes_in_valid <= grant_any;
      if (grant_any) aes_in_data <= sel_data;
      tag_v  <= {tag_v[LATENCY-1:0], grant_any};
      tag_id <= {tag_id[LATENCY-1:0], grant_id};
    end
  end

  // -------------------------------------------------------------------------
  // In-flight counter
  // -------------------------------------------------------------------------
  // A block is counted from the edge that presents it to the datapath until
  // the edge on which its ciphertext retires.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      inflight <= '0;
    end else begin
      case ({aes_in_valid, retire})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Tag check with post-reset drain mask
  // -------------------------------------------------------------------------
  // The datapath has no reset and keeps emitting blocks issued before reset.
  // Tag mismatches are ignored for LATENCY+1 cycles after reset is released,
  // which is long enough for that stale traffic to flush out. A strobe
  // without a tag is never written to a FIFO, because retire needs tag_out_v.
  logic [MW-1:0] mask_cnt;
  logic          masked;

  assign masked = (mask_cnt != '0);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mask_cnt <= MW'(LATENCY + 1);
    end else if (masked) begin
      mask_cnt <= mask_cnt - MW'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      err_tag <= 1'b0;
    end else if (!masked && (aes_out_valid != tag_out_v)) begin
      err_tag <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-requester result FIFO and credit counter
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NREQ; g++) begin : g_req
    logic [127:0] mem [RES_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [CW-1:0] credit;
    logic         wr;
    logic         pop;
    logic         full;

    assign wr   = retire && (tag_out_id == IDW'(g));
    assign pop  = res_valid[g] & res_ready[g];
    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign res_valid[g]           = (wr_ptr != rd_ptr);
    assign res_data[128*g +: 128] = res_valid[g] ? mem[rd_ptr[AW-1:0]] : '0;
    assign has_credit[g]          = (credit != '0);

    always_ff @(posedge clk_clk) begin
      if (wr) mem[wr_ptr[AW-1:0]] <= aes_out_data;
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end

    // A grant and a pop in the same cycle cancel out.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        credit <= CW'(RES_DEPTH);
      end else begin
        case ({grant[g], pop})
          2'b10:   credit <= credit - CW'(1);
          2'b01:   credit <= credit + CW'(1);
          default: credit <= credit;
        endcase
      end
    end

    // The credit scheme reserves a slot before every issue, so a write into
    // a full FIFO means the credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk_clk) disable iff (reset_reset)
                                    !(wr && full));
  end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_scheduler
//
// Self-checking bench for aes_enc_scheduler (NREQ=2, LATENCY=14, RES_DEPTH=4).
// A behavioural datapath stand-in delays blocks by LATENCY cycles. It maps
// the FIPS-197 C.3 plaintext to its published ciphertext and scrambles every
// other block with a fixed bijection. The reference model is built from
// credits, a round-robin pointer and per-requester queues of expected
// ciphertexts with their due cycle. A separate monitor compares the result
// ports against those queues.
// ---------------------------------------------------------------------------
module tb_aes_enc_scheduler;

  localparam int NREQ      = 2;
  localparam int LATENCY   = 14;
  localparam int RES_DEPTH = 4;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MIXK    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  // ---------------- clock / reset / DUT ----------------
  logic                clk_clk = 1'b0;
  logic                reset_reset = 1'b1;
  logic                key_ready = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [128*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                aes_in_valid;
  logic [127:0]        aes_in_data;
  logic                aes_out_valid = 1'b0;
  logic [127:0]        aes_out_data = '0;
  logic [NREQ-1:0]     res_valid;
  logic [128*NREQ-1:0] res_data;
  logic [NREQ-1:0]     res_ready = '0;
  logic [4:0]          inflight;
  logic                err_tag;

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  aes_enc_scheduler #(.NREQ(NREQ), .LATENCY(LATENCY), .RES_DEPTH(RES_DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .key_ready(key_ready),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .aes_in_valid(aes_in_valid), .aes_in_data(aes_in_data),
    .aes_out_valid(aes_out_valid), .aes_out_data(aes_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .inflight(inflight), .err_tag(err_tag)
  );

  // ---------------- counters and check helper ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [127:0] cipher(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return {pt[95:0], pt[127:96]} ^ MIXK;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- datapath stand-in (LATENCY cycles, no reset) ----------
  logic         dp_v [LATENCY];
  logic [127:0] dp_d [LATENCY];
  logic         inj_pend = 1'b0;
  logic         inj_active = 1'b0;
  logic         pv;
  logic [127:0] pd;

  initial begin
    for (int k = 0; k < LATENCY; k++) begin
      dp_v[k] = 1'b0;
      dp_d[k] = '0;
    end
    forever begin
      @(negedge clk_clk);
      pv = aes_in_valid;
      pd = aes_in_data;
      @(posedge clk_clk);
      #1;
      for (int k = LATENCY - 1; k > 0; k--) begin
        dp_v[k] = dp_v[k-1];
        dp_d[k] = dp_d[k-1];
      end
      dp_v[0]       = pv;
      dp_d[0]       = pd;
      inj_active    = inj_pend && !dp_v[LATENCY-1];
      inj_pend      = 1'b0;
      aes_out_valid = dp_v[LATENCY-1] | inj_active;
      aes_out_data  = dp_v[LATENCY-1] ? cipher(dp_d[LATENCY-1]) :
                      (inj_active ? 128'hdeadbeef_0badf00d_12345678_9abcdef0 : '0);
    end
  end

  // ---------------- reference model + scoreboard queues ----------------
  logic [127:0] exp_q [NREQ][$];   // expected ciphertexts per requester
  int           due_q [NREQ][$];   // cycle from which each may appear
  int           issue_q[$];        // cycles in which blocks sat on aes_in
  int           cred [NREQ];
  int           rr;
  int           gid;
  int           idx;
  int           n_in;
  int           mask_left;
  int           peak;
  int           gcount [NREQ];
  logic         err_exp;
  logic         prev_grant;
  logic [127:0] prev_data;
  logic [NREQ-1:0] g_exp;

  initial begin
    peak = 0;
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
    forever begin
      @(negedge clk_clk);
      if (reset_reset) begin
        for (int i = 0; i < NREQ; i++) begin
          exp_q[i].delete();
          due_q[i].delete();
          cred[i] = RES_DEPTH;
        end
        issue_q.delete();
        rr         = 0;
        prev_grant = 1'b0;
        prev_data  = '0;
        err_exp    = 1'b0;
        mask_left  = LATENCY + 1;
        continue;
      end
      // Expected grant: first requester from rr onward that can take a block.
      gid = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (gid < 0 && key_ready && req_valid[idx] && cred[idx] > 0) gid = idx;
      end
      g_exp = '0;
      if (gid >= 0) g_exp[gid] = 1'b1;
      check("req_ready", req_ready, g_exp);
      check("aes_in_valid", aes_in_valid, prev_grant);
      if (prev_grant) check("aes_in_data", aes_in_data, prev_data);
      // Blocks present on aes_in in cycle e are in the datapath for e+1..e+LATENCY.
      while (issue_q.size() > 0 && issue_q[0] + LATENCY < cyc) void'(issue_q.pop_front());
      n_in = 0;
      foreach (issue_q[j]) if (issue_q[j] < cyc) n_in++;
      check("inflight", inflight, n_in);
      check("err_tag", err_tag, err_exp);
      if (int'(inflight) > peak) peak = int'(inflight);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gcount[i]++;
      // Advance the model to the state after the coming edge.
      if (inj_active && mask_left == 0) err_exp = 1'b1;
      if (mask_left > 0) mask_left--;
      for (int i = 0; i < NREQ; i++) begin
        if (res_ready[i] && exp_q[i].size() > 0 && due_q[i][0] <= cyc) cred[i]++;
      end
      prev_grant = (gid >= 0);
      if (gid >= 0) begin
        cred[gid]--;
        rr        = (gid + 1) % NREQ;
        prev_data = req_data[128*gid +: 128];
        exp_q[gid].push_back(cipher(prev_data));
        due_q[gid].push_back(cyc + LATENCY + 2);
        issue_q.push_back(cyc + 1);
      end
    end
  end

  // ---------------- monitor: pops and compares result ports ----------------
  logic due_now;
  initial begin
    forever begin
      @(negedge clk_clk);
      #1;
      if (reset_reset) continue;
      for (int i = 0; i < NREQ; i++) begin
        due_now = exp_q[i].size() > 0 && due_q[i][0] <= cyc;
        check($sformatf("res_valid[%0d]", i), res_valid[i], due_now);
        if (due_now && res_valid[i])
          check($sformatf("res_data[%0d]", i), res_data[128*i +: 128], exp_q[i][0]);
        if (due_now && res_ready[i]) begin
          void'(exp_q[i].pop_front());
          void'(due_q[i].pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // n cycles with the given valid/ready masks and fresh random plaintext.
  task automatic drive(input int n, input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
    for (int c = 0; c < n; c++) begin
      req_valid = v;
      res_ready = r;
      for (int i = 0; i < NREQ; i++) req_data[128*i +: 128] = rand128();
      step();
    end
  endtask

  task automatic drive_random(input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      res_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      key_ready = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++) req_data[128*i +: 128] = rand128();
      step();
    end
    key_ready = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  int g_cyc;
  int wait_n;
  int g0;
  int g1;
  logic seen;

  initial begin
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset = 1'b0;
    // Reset values, one cycle after release.
    @(negedge clk_clk);
    check("reset req_ready", req_ready, '0);
    check("reset res_valid", res_valid, '0);
    check("reset inflight", inflight, 0);
    check("reset err_tag", err_tag, 1'b0);
    step();

    // T1: known-answer block, grant to res_valid latency.
    key_ready = 1'b1;
    res_ready = '1;
    req_data[127:0] = FIPS_PT;
    req_valid = 2'b01;
    seen = 1'b0;
    g_cyc = 0;
    for (wait_n = 0; wait_n < 10 && !seen; wait_n++) begin
      @(negedge clk_clk);
      if (req_ready[0]) begin
        seen  = 1'b1;
        g_cyc = cyc;
      end
    end
    check("t1 grant seen", seen, 1'b1);
    step();
    req_valid = '0;
    seen = 1'b0;
    for (wait_n = 0; wait_n < 40 && !seen; wait_n++) begin
      @(negedge clk_clk);
      if (res_valid[0]) begin
        seen = 1'b1;
        check("t1 latency", cyc - g_cyc, LATENCY + 2);
        check("t1 ciphertext", res_data[127:0], FIPS_CT);
      end
    end
    check("t1 result seen", seen, 1'b1);
    step();

    // T2: both requesters streaming, results drained at once. The total
    // credit pool bounds the occupancy of the datapath.
    peak = 0;
    drive(60, 2'b11, 2'b11);
    drive(25, 2'b00, 2'b11);
    check("t2 inflight peak", peak,
          (LATENCY < NREQ * RES_DEPTH) ? LATENCY : NREQ * RES_DEPTH);

    // T3: requester 0 credit-starved, requester 1 keeps flowing.
    g0 = gcount[0];
    g1 = gcount[1];
    drive(30, 2'b11, 2'b10);
    check("t3 grants to starved req0", gcount[0] - g0, RES_DEPTH);
    check("t3 req1 kept granted", (gcount[1] - g1) > RES_DEPTH, 1'b1);
    drive(1, 2'b11, 2'b11);
    drive(6, 2'b11, 2'b10);
    check("t3 one pop one grant", gcount[0] - g0, RES_DEPTH + 1);
    drive(25, 2'b00, 2'b11);

    // T4: key_ready dropped for 5 cycles mid-burst.
    drive(6, 2'b11, 2'b11);
    g0 = gcount[0] + gcount[1];
    key_ready = 1'b0;
    drive(5, 2'b11, 2'b11);
    check("t4 no grants while key low", gcount[0] + gcount[1] - g0, 0);
    key_ready = 1'b1;
    req_valid = 2'b11;
    @(negedge clk_clk);
    check("t4 issue resumes", req_ready != '0, 1'b1);
    step();
    drive(25, 2'b00, 2'b11);

    // Randomized traffic.
    drive_random(400);
    drive(30, 2'b00, 2'b11);

    // T5: reset with blocks in flight, stale ciphertext during the mask.
    drive(10, 2'b11, 2'b00);
    check("t5 blocks in flight", inflight > 5'd4, 1'b1);
    req_valid = '0;
    reset_reset = 1'b1;
    step();
    step();
    reset_reset = 1'b0;
    drive(LATENCY + 4, 2'b00, 2'b11);
    check("t5 err_tag masked", err_tag, 1'b0);
    check("t5 fifos empty", res_valid, '0);
    g0 = gcount[0];
    drive(12, 2'b01, 2'b00);
    check("t5 credits restored", gcount[0] - g0, RES_DEPTH);
    drive(25, 2'b00, 2'b11);

    // T6: untagged strobe outside the mask window.
    @(negedge clk_clk);
    #1;
    inj_pend = 1'b1;
    drive(4, 2'b00, 2'b11);
    check("t6 err_tag set", err_tag, 1'b1);
    check("t6 no fifo write", res_valid, '0);
    drive(10, 2'b00, 2'b11);
    check("t6 err_tag sticky", err_tag, 1'b1);

    for (int i = 0; i < NREQ; i++)
      check($sformatf("leftover expected[%0d]", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
